playseq_preview_ctrl: RTL and testbench
=======================================

Name: playseq_preview_ctrl

Overview:
Sequencer for the PlaySeq LED preview phase. On a start pulse it walks the sequence memory from address 0 to a latched limit. For each address it lights the stored LED pattern for T_ON cycles, then blanks the LEDs for T_OFF cycles. It sits between the unit controller and the datapath memory/LED outputs, and replaces ad-hoc preview timing in the UC with a single start/done handshake.

Parameters:
T_ON, 4, cycles each pattern is shown (>=1)
T_OFF, 2, blank cycles after each pattern (>=1)
TIMER_W, 16, timer width; must hold max(T_ON, T_OFF)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
iniciar  in  1  start request, sampled only in OCIOSO
limite  in  4  index of last address to show (sequence length minus 1), latched on start
pausa  in  1  freeze: state, timer, endereco and leds hold while high
dado_memoria  in  4  LED pattern read combinationally from memory at endereco
endereco  out  4  memory address being shown (registered)
leds  out  4  registered LED drive
ocupado  out  1  high in every state except OCIOSO
pronto  out  1  one-cycle done pulse
db_estado  out  4  current state code, for hexa7seg display

Behaviour:
- Reset (synchronous, any state, including mid-preview):
  - next state OCIOSO
  - endereco=0, leds=0, pronto=0, ocupado=0, timer=0, limite_reg=0
- State codes: OCIOSO=0, CARREGA=1, ACENDE=2, APAGA=3, FIM=4. Unused codes go to OCIOSO on the next edge.
- OCIOSO:
  - leds=0, endereco=0.
  - If iniciar=1: limite_reg<=limite and go to CARREGA.
- CARREGA: one cycle. At the exit edge: leds<=dado_memoria, timer<=0, go to ACENDE.
- ACENDE:
  - leds holds the pattern; timer increments each cycle.
  - When timer==T_ON-1: timer<=0, leds<=0, go to APAGA.
- APAGA:
  - leds=0; timer increments.
  - When timer==T_OFF-1:
    - if endereco==limite_reg, go to FIM;
    - else endereco<=endereco+1 and go to CARREGA.
- FIM: pronto=1 for exactly this cycle. Unconditional next state OCIOSO; endereco<=0.
- Outputs:
  - pronto is Moore-decoded from FIM.
  - ocupado=1 in CARREGA, ACENDE, APAGA and FIM.
  - db_estado = state code zero-extended to 4 bits.
- Latency:
  - Cycles per entry = 1 + T_ON + T_OFF.
  - With iniciar sampled at edge e0, pronto is high during cycle e0 + (limite+1)*(1+T_ON+T_OFF) + 1.
- pausa:
  - When high, all registers hold, except that reset still wins.
  - In OCIOSO, pausa has no effect on start acceptance; iniciar is accepted regardless.
- iniciar outside OCIOSO (including in FIM) is ignored; no restart and no queuing.
- limite changes after start have no effect, because limite_reg is used.
- limite=15 shows all 16 addresses. endereco never exceeds limite_reg, so it cannot wrap.
- limite=0 shows only address 0.
- dado_memoria is passed through unchecked; non-one-hot patterns appear as given.
- Arithmetic:
  - endereco increments as 4-bit unsigned.
  - The timer is TIMER_W bits and is compared for equality to parameter minus 1.

Test Plan:
1. T_ON=3, T_OFF=2; memory 0:0001, 1:0010, 2:0100; limite=2; pulse iniciar 1 cycle -> leds sequence 0001x3, 0000x2, 0010x3, 0000x2, 0100x3, 0000x2 (each pattern preceded by one CARREGA cycle); pronto high exactly at cycle 19 after the start edge; ocupado high cycles 1-19.
2. limite=0, memory 0:1000 -> leds=1000 for 3 cycles, then 0000 for 2; pronto at cycle 7; endereco stays 0 throughout.
3. Mid-ACENDE (address 1, leds=0010), assert pausa for 5 cycles -> leds, endereco, db_estado=2 and timer frozen; after release, the remaining ACENDE cycles complete; total completion delayed by exactly 5 cycles.
4. Reset asserted in APAGA at address 1 -> next cycle: state 0, endereco=0, leds=0, ocupado=0, no pronto pulse.
5. iniciar re-pulsed during ACENDE and during FIM, and limite changed to 5 mid-run -> run completes at original limite 2; exactly one pronto pulse; returns to OCIOSO.
6. limite=15, 16 distinct patterns -> endereco steps 0..15 with no wrap; pronto at cycle 16*6+1=97.

Source files
------------

// File: rtl/playseq_preview_if.sv
// Handshake and memory/LED signals between the unit controller and the preview sequencer.
// The master side drives the request and the memory data; the slave side is the sequencer.
interface playseq_preview_if;
    logic       iniciar;
    logic [3:0] limite;
    logic       pausa;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output iniciar, limite, pausa, dado_memoria,
        input  endereco, leds, ocupado, pronto, db_estado
    );

    modport slave (
        input  iniciar, limite, pausa, dado_memoria,
        output endereco, leds, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/playseq_preview_ctrl.sv
// PlaySeq LED preview sequencer: walks memory 0..limite, showing each pattern for T_ON
// cycles followed by T_OFF blank cycles, then pulses pronto for one cycle.
module playseq_preview_ctrl #(
    parameter int T_ON    = 4,
    parameter int T_OFF   = 2,
    parameter int TIMER_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    playseq_preview_if.slave         bus
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        FIM     = 3'd4
    } state_t;

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(T_OFF - 1);

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         limite_reg;
    logic [3:0]         endereco;
    logic [3:0]         leds;
    logic               hold;
    logic               on_done;
    logic               off_done;
    logic               last_addr;

    // pausa freezes only an active run; idle always stays responsive to iniciar
    always_comb begin
        hold = 1'b0;
        case (state)
            CARREGA, ACENDE, APAGA, FIM: hold = bus.pausa;
            default:                     hold = 1'b0;
        endcase
    end

    assign on_done   = (timer == ON_LAST);
    assign off_done  = (timer == OFF_LAST);
    assign last_addr = (endereco == limite_reg);

    always_ff @(posedge clock) begin
        if (reset)
            state <= OCIOSO;
        else if (!hold)
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            OCIOSO:  if (bus.iniciar) state_next = CARREGA;
            CARREGA: state_next = ACENDE;
            ACENDE:  if (on_done) state_next = APAGA;
            APAGA:   if (off_done) state_next = last_addr ? FIM : CARREGA;
            FIM:     state_next = OCIOSO;
            default: state_next = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer      <= '0;
            limite_reg <= '0;
            endereco   <= '0;
            leds       <= '0;
        end else if (!hold) begin
            case (state)
                OCIOSO: begin
                    timer    <= '0;
                    endereco <= '0;
                    leds     <= '0;
                    if (bus.iniciar)
                        limite_reg <= bus.limite;
                end
                CARREGA: begin
                    timer <= '0;
                    leds  <= bus.dado_memoria;
                end
                ACENDE: begin
                    if (on_done) begin
                        timer <= '0;
                        leds  <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGA: begin
                    leds <= '0;
                    // endereco stops at limite_reg, so it can never wrap past 15
                    if (off_done) begin
                        timer <= '0;
                        if (!last_addr)
                            endereco <= endereco + 4'd1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FIM: begin
                    timer    <= '0;
                    endereco <= '0;
                    leds     <= '0;
                end
                default: begin
                    timer    <= '0;
                    endereco <= '0;
                    leds     <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.ocupado   = 1'b0;
        bus.pronto    = 1'b0;
        bus.db_estado = {1'b0, state};
        case (state)
            CARREGA, ACENDE, APAGA: bus.ocupado = 1'b1;
            FIM: begin
                bus.ocupado = 1'b1;
                bus.pronto  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.endereco = endereco;
    assign bus.leds     = leds;

endmodule

// File: tb/tb_playseq_preview_ctrl.sv
// Directed bench for playseq_preview_ctrl with T_ON=3, T_OFF=2 (6 cycles per entry).
// Observed vector per cycle: {endereco, leds, ocupado, pronto, db_estado}.
module tb_playseq_preview_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] mem [16];

    playseq_preview_if bus();

    playseq_preview_ctrl #(.T_ON(3), .T_OFF(2), .TIMER_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.dado_memoria = mem[bus.endereco];

    function automatic logic [13:0] obs();
        return {bus.endereco, bus.leds, bus.ocupado, bus.pronto, bus.db_estado};
    endfunction

    // Expected vector for cycle c after the start edge (cycle 1 = CARREGA of address 0).
    function automatic logic [13:0] exp_vec(int c, int lim);
        int n, ent, ph;
        logic [3:0] a, l, st;
        logic o, p;
        n = (lim + 1) * 6;
        a = 4'd0; l = 4'd0; st = 4'd0; o = 1'b0; p = 1'b0;
        if (c >= 1 && c <= n) begin
            ent = (c - 1) / 6;
            ph  = (c - 1) % 6;
            a   = 4'(ent);
            o   = 1'b1;
            if (ph == 0) st = 4'd1;
            else if (ph <= 3) begin st = 4'd2; l = mem[a]; end
            else st = 4'd3;
        end else if (c == n + 1) begin
            a = 4'(lim); o = 1'b1; p = 1'b1; st = 4'd4;
        end
        return {a, l, o, p, st};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [3:0] lim);
        bus.limite  = lim;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        reset = 1'b1;
        bus.iniciar = 1'b0;
        bus.pausa = 1'b0;
        bus.limite = 4'd0;
        tick(); tick();
        got = obs();
        total++;
        if (got !== 14'h0) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", got, 14'h0);
        end
        reset = 1'b0;
        tick();
        got = obs();
        total++;
        if (got !== 14'h0) begin
            bad++;
            $display("FAIL idle_after_reset got=%h want=%h", got, 14'h0);
        end
    endtask

    task automatic test_basic();
        logic [13:0] got, want;
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        start(4'd2);
        for (int c = 1; c <= 21; c++) begin
            got = obs(); want = exp_vec(c, 2);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL basic c=%0d got=%h want=%h", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_single();
        logic [13:0] got, want;
        mem[0] = 4'b1000;
        // pausa while idle must not block the start
        bus.pausa = 1'b1;
        start(4'd0);
        bus.pausa = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            got = obs(); want = exp_vec(c, 0);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single c=%0d got=%h want=%h", c, got, want);
            end
            tick();
        end
    endtask

    task automatic test_pause();
        logic [13:0] got, want;
        mem[0] = 4'b0001; mem[1] = 4'b0010; mem[2] = 4'b0100;
        start(4'd2);
        for (int c = 1; c <= 26; c++) begin
            if (c <= 9)       want = exp_vec(c, 2);
            else if (c <= 14) want = exp_vec(9, 2);
            else              want = exp_vec(c - 5, 2);
            got = obs();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL pause c=%0d got=%h want=%h", c, got, want);
            end
            if (c == 9)  bus.pausa = 1'b1;
            if (c == 14) bus.pausa = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] got, want;
        start(4'd2);
        for (int c = 1; c <= 11; c++) tick();
        // cycle 12 is APAGA of address 1
        got = obs(); want = exp_vec(11, 2);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL pre_reset got=%h want=%h", got, want);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            got = obs();
            total++;
            if (got !== 14'h0) begin
                bad++;
                $display("FAIL reset_mid k=%0d got=%h want=%h", c, got, 14'h0);
            end
            tick();
        end
    endtask

    task automatic test_ignore_restart();
        logic [13:0] got, want;
        int pulses;
        pulses = 0;
        start(4'd2);
        for (int c = 1; c <= 26; c++) begin
            got = obs(); want = exp_vec(c, 2);
            if (bus.pronto === 1'b1) pulses++;
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL ignore_restart c=%0d got=%h want=%h", c, got, want);
            end
            bus.iniciar = (c == 3 || c == 19) ? 1'b1 : 1'b0;
            if (c == 4) bus.limite = 4'd5;
            tick();
        end
        bus.iniciar = 1'b0;
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL pronto_count got=%0d want=%0d", pulses, 1);
        end
    endtask

    task automatic test_full();
        logic [13:0] got, want;
        for (int i = 0; i < 16; i++) mem[i] = 4'(15 - i);
        start(4'd15);
        for (int c = 1; c <= 99; c++) begin
            got = obs(); want = exp_vec(c, 15);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full c=%0d got=%h want=%h", c, got, want);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        bus.iniciar = 1'b0;
        bus.pausa   = 1'b0;
        bus.limite  = 4'd0;
        test_reset();
        test_basic();
        test_single();
        test_pause();
        test_reset_mid();
        test_ignore_restart();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
